// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared tile codes, coordinate width and arbiter state encoding
package game_pkg;

  localparam int COORD_W = 4;

  localparam logic [1:0] TILE_FLOOR = 2'd0;
  localparam logic [1:0] TILE_WALL  = 2'd1;
  localparam logic [1:0] TILE_EXIT  = 2'd2;
  localparam logic [1:0] TILE_BLOCK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_CHECK  = 2'd2,
    S_GRANT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/move_arbiter_if.sv
// rtl/move_arbiter_if.sv - mover request/grant bus plus the shared map-read port
interface move_arbiter_if
  import game_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]         ask_move;
  logic [COORD_W*N_REQ-1:0] ask_x;
  logic [COORD_W*N_REQ-1:0] ask_y;
  logic [COORD_W*N_REQ-1:0] pos_x;
  logic [COORD_W*N_REQ-1:0] pos_y;
  logic [COORD_W-1:0]       map_rd_x;
  logic [COORD_W-1:0]       map_rd_y;
  logic [1:0]               map_rd_data;
  logic [N_REQ-1:0]         accept_move;
  logic [COORD_W-1:0]       goto_x;
  logic [COORD_W-1:0]       goto_y;

  modport master (
    output ask_move, ask_x, ask_y, pos_x, pos_y, map_rd_data,
    input  map_rd_x, map_rd_y, accept_move, goto_x, goto_y
  );

  modport slave (
    input  ask_move, ask_x, ask_y, pos_x, pos_y, map_rd_data,
    output map_rd_x, map_rd_y, accept_move, goto_x, goto_y
  );
endinterface

// File: rtl/move_arbiter_rr_pick.sv
// rtl/move_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [2*N_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Doubling the vector turns the wrap-around search into a plain shift.
    rot = {req, req} >> ptr;
    any = 1'b0;
    off = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx   = sum[IDX_W-1:0];
    grant = any ? (N_REQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - serialises mover tile-move requests through one map-read port
module move_arbiter
  import game_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAP_W = 13,
  parameter int MAP_H = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  move_arbiter_if.slave bus,
  output logic          busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t state, next_state;

  logic [IDX_W-1:0]   rr_ptr, sel, pick_idx;
  logic [N_REQ-1:0]   sel_oh, pick_grant, occ_hit;
  logic               pick_any, start, in_bounds, passable, occupied, legal;
  logic [COORD_W-1:0] tgt_x, tgt_y, cur_x, cur_y;
  logic [COORD_W-1:0] ask_sel_x, ask_sel_y, pos_sel_x, pos_sel_y;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.ask_move),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign start = en & pick_any;
  assign busy  = (state != S_IDLE);

  always_comb begin
    ask_sel_x = '0;
    ask_sel_y = '0;
    pos_sel_x = '0;
    pos_sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        ask_sel_x = bus.ask_x[i*COORD_W +: COORD_W];
        ask_sel_y = bus.ask_y[i*COORD_W +: COORD_W];
        pos_sel_x = bus.pos_x[i*COORD_W +: COORD_W];
        pos_sel_y = bus.pos_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Live positions: a mover granted just before this one has already moved.
  for (genvar j = 0; j < N_REQ; j++) begin : g_occ
    assign occ_hit[j] = ~sel_oh[j]
                      && (bus.pos_x[j*COORD_W +: COORD_W] == tgt_x)
                      && (bus.pos_y[j*COORD_W +: COORD_W] == tgt_y);
  end

  assign occupied  = |occ_hit;
  assign in_bounds = ({1'b0, tgt_x} < (COORD_W+1)'(MAP_W))
                  && ({1'b0, tgt_y} < (COORD_W+1)'(MAP_H));
  assign passable  = (bus.map_rd_data == TILE_FLOOR) || (bus.map_rd_data == TILE_EXIT);
  assign legal     = in_bounds & passable & ~occupied;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOOKUP;
      S_LOOKUP: next_state = S_CHECK;
      S_CHECK:  next_state = S_GRANT;
      S_GRANT:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      sel             <= '0;
      sel_oh          <= '0;
      tgt_x           <= '0;
      tgt_y           <= '0;
      cur_x           <= '0;
      cur_y           <= '0;
      bus.map_rd_x    <= '0;
      bus.map_rd_y    <= '0;
      bus.accept_move <= '0;
      bus.goto_x      <= '0;
      bus.goto_y      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel          <= pick_idx;
            sel_oh       <= pick_grant;
            tgt_x        <= ask_sel_x;
            tgt_y        <= ask_sel_y;
            cur_x        <= pos_sel_x;
            cur_y        <= pos_sel_y;
            bus.map_rd_x <= ask_sel_x;
            bus.map_rd_y <= ask_sel_y;
          end
        end
        S_CHECK: begin
          bus.goto_x      <= legal ? tgt_x : cur_x;
          bus.goto_y      <= legal ? tgt_y : cur_y;
          bus.accept_move <= sel_oh;
        end
        S_GRANT: begin
          bus.accept_move <= '0;
          rr_ptr          <= (sel == IDX_W'(N_REQ-1)) ? '0 : sel + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
